// File: rtl/jtag_ir_dr.sv
// jtag_ir_dr -- instruction and data register stage behind a JTAG TAP controller.
//
// The TAP controller supplies its current state on tap_state. This block
// implements the instruction register, the IDCODE, BYPASS and USER data
// registers, and the registered tdo mux. USER gives the core a parallel
// capture (user_in) and update (user_out / user_update) window.
//
// Ports:
//   tck          in   sole clock, all logic on the rising edge
//   trst         in   synchronous active-high reset
//   tap_state    in   4-bit TAP state encoding from the controller
//   tdi          in   serial data in
//   tdo          out  registered serial data out
//   tdo_en       out  high while tdo carries shifted data
//   user_in      in   parallel value captured into USER on CaptureDr
//   user_out     out  last value written by UpdateDr under USER
//   user_update  out  one-cycle pulse when user_out is written
//   ir_out       out  active instruction
module jtag_ir_dr #(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
    parameter int          USER_WIDTH   = 8   // must be >= 2
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic [3:0]            tap_state,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    input  logic [USER_WIDTH-1:0] user_in,
    output logic [USER_WIDTH-1:0] user_out,
    output logic                  user_update,
    output logic [IR_WIDTH-1:0]   ir_out
);

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(4'b0001);
    localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(4'b1000);

    // One shift register serves both IDCODE and USER; it must hold the wider.
    localparam int DR_W = (USER_WIDTH > 32) ? USER_WIDTH : 32;

    tap_state_e st;
    assign st = tap_state_e'(tap_state);

    logic [IR_WIDTH-1:0]   ir_q;
    logic [IR_WIDTH-1:0]   ir_shift_q;
    logic [DR_W-1:0]       dr_shift_q;
    logic                  bypass_q;
    logic [USER_WIDTH-1:0] user_out_q;
    logic                  user_update_q;
    logic                  tdo_q;
    logic                  tdo_en_q;

    always_ff @(posedge tck) begin
        if (trst || st == TEST_LOGIC_RESET) begin
            ir_q          <= OP_IDCODE;
            ir_shift_q    <= '0;
            dr_shift_q    <= '0;
            bypass_q      <= 1'b0;
            user_out_q    <= '0;
            user_update_q <= 1'b0;
            tdo_q         <= 1'b0;
            tdo_en_q      <= 1'b0;
        end else begin
            user_update_q <= 1'b0;
            tdo_en_q      <= (st == SHIFT_IR) || (st == SHIFT_DR);
            case (st)
                CAPTURE_IR: ir_shift_q <= IR_WIDTH'(2'b01);
                SHIFT_IR: begin
                    tdo_q      <= ir_shift_q[0];
                    ir_shift_q <= {tdi, ir_shift_q[IR_WIDTH-1:1]};
                end
                UPDATE_IR: ir_q <= ir_shift_q;
                CAPTURE_DR: begin
                    case (ir_q)
                        OP_IDCODE: dr_shift_q <= DR_W'(IDCODE_VALUE);
                        OP_USER:   dr_shift_q[USER_WIDTH-1:0] <= user_in;
                        default:   bypass_q <= 1'b0;
                    endcase
                end
                SHIFT_DR: begin
                    // tdi enters at the MSB of the selected register's width,
                    // so over-long scans pass tdi through after N edges.
                    case (ir_q)
                        OP_IDCODE: begin
                            tdo_q            <= dr_shift_q[0];
                            dr_shift_q[31:0] <= {tdi, dr_shift_q[31:1]};
                        end
                        OP_USER: begin
                            tdo_q <= dr_shift_q[0];
                            dr_shift_q[USER_WIDTH-1:0] <=
                                {tdi, dr_shift_q[USER_WIDTH-1:1]};
                        end
                        default: begin
                            tdo_q    <= bypass_q;
                            bypass_q <= tdi;
                        end
                    endcase
                end
                UPDATE_DR: begin
                    if (ir_q == OP_USER) begin
                        user_out_q    <= dr_shift_q[USER_WIDTH-1:0];
                        user_update_q <= 1'b1;
                    end
                end
                default: ;  // Select/Exit/Pause/RunTestIdle hold everything
            endcase
        end
    end

    assign tdo         = tdo_q;
    assign tdo_en      = tdo_en_q;
    assign user_out    = user_out_q;
    assign user_update = user_update_q;
    assign ir_out      = ir_q;

endmodule

// File: tb/tb_jtag_ir_dr.sv
module tb_jtag_ir_dr;

    localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SELDR = 4'd2, CAPDR = 4'd3,
                           SHDR = 4'd4, EX1DR = 4'd5, PSDR = 4'd6, EX2DR = 4'd7,
                           UPDR = 4'd8, SELIR = 4'd9, CAPIR = 4'd10, SHIR = 4'd11,
                           EX1IR = 4'd12, UPIR = 4'd15;

    logic       tck = 1'b0;
    logic       trst = 1'b0;
    logic [3:0] tap_state = TLR;
    logic       tdi = 1'b0;
    logic       tdo, tdo_en, user_update;
    logic [7:0] user_in = 8'h00;
    logic [7:0] user_out;
    logic [3:0] ir_out;

    int n_chk  = 0;
    int n_fail = 0;

    jtag_ir_dr dut (
        .tck(tck), .trst(trst), .tap_state(tap_state), .tdi(tdi),
        .tdo(tdo), .tdo_en(tdo_en), .user_in(user_in), .user_out(user_out),
        .user_update(user_update), .ir_out(ir_out)
    );

    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Apply state/tdi, take one rising edge, settle 1 time unit past it.
    task automatic clk(input logic [3:0] s, input logic d);
        tap_state = s;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    // From RunTestIdle: full IR scan of op, returns the 4 bits seen on tdo.
    task automatic load_ir(input logic [3:0] op, output logic [3:0] seen);
        clk(SELDR, 0); clk(SELIR, 0); clk(CAPIR, 0);
        for (int i = 0; i < 4; i++) begin
            clk(SHIR, op[i]);
            seen[i] = tdo;
        end
        clk(EX1IR, 0); clk(UPIR, 0); clk(RTI, 0);
    endtask

    task automatic test_reset;
        trst = 1'b1;
        clk(RTI, 0); clk(RTI, 0);
        n_chk++; if (ir_out !== 4'b0001) begin n_fail++; $display("FAIL reset_ir: got %h want 1", ir_out); end
        n_chk++; if (tdo !== 1'b0 || tdo_en !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got tdo=%b en=%b want 0 0", tdo, tdo_en); end
        n_chk++; if (user_out !== 8'h00 || user_update !== 1'b0) begin n_fail++; $display("FAIL reset_user: got %h/%b want 00/0", user_out, user_update); end
        trst = 1'b0;
        clk(RTI, 0);
    endtask

    task automatic test_idcode;
        logic [31:0] got;
        int en_bad;
        en_bad = 0;
        clk(SELDR, 0); clk(CAPDR, 0);
        for (int i = 0; i < 32; i++) begin
            clk(SHDR, 0);
            got[i] = tdo;
            if (tdo_en !== 1'b1) en_bad++;
        end
        n_chk++; if (got !== 32'h1000_0001) begin n_fail++; $display("FAIL idcode_read: got %h want 10000001", got); end
        n_chk++; if (en_bad != 0) begin n_fail++; $display("FAIL idcode_tdo_en: got %0d low cycles want 0", en_bad); end
        clk(EX1DR, 0);
        n_chk++; if (tdo_en !== 1'b0) begin n_fail++; $display("FAIL idcode_en_off: got %b want 0", tdo_en); end
        clk(UPDR, 0);
        n_chk++; if (user_update !== 1'b0) begin n_fail++; $display("FAIL idcode_no_update: got %b want 0", user_update); end
        clk(RTI, 0);
    endtask

    task automatic test_ir_load;
        logic [3:0] seen;
        load_ir(4'b1111, seen);
        n_chk++; if (seen !== 4'b0001) begin n_fail++; $display("FAIL ir_capture: got %b want 0001 (1,0,0,0)", seen); end
        n_chk++; if (ir_out !== 4'b1111) begin n_fail++; $display("FAIL ir_load: got %b want 1111", ir_out); end
    endtask

    task automatic dr_bypass_check(input string nm);
        logic [3:0] pat, got;
        pat = 4'b1101;  // tdi 1,0,1,1 LSB first
        clk(SELDR, 0); clk(CAPDR, 0);
        for (int i = 0; i < 4; i++) begin
            clk(SHDR, pat[i]);
            got[i] = tdo;
        end
        n_chk++; if (got !== 4'b1010) begin n_fail++; $display("FAIL %s: got %b want 1010 (0,1,0,1)", nm, got); end
        clk(EX1DR, 0); clk(UPDR, 0);
        n_chk++; if (user_update !== 1'b0 || user_out !== 8'h00) begin n_fail++; $display("FAIL %s_update: got %b/%h want 0/00", nm, user_update, user_out); end
        clk(RTI, 0);
    endtask

    task automatic test_bypass;
        dr_bypass_check("bypass");
    endtask

    task automatic test_user;
        logic [3:0] seen;
        logic [7:0] pat, got;
        int pulses;
        load_ir(4'b1000, seen);
        n_chk++; if (ir_out !== 4'b1000) begin n_fail++; $display("FAIL user_ir: got %b want 1000", ir_out); end
        user_in = 8'hA5;
        pat = 8'h3C;
        clk(SELDR, 0); clk(CAPDR, 0);
        user_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clk(SHDR, pat[i]);
            got[i] = tdo;
        end
        n_chk++; if (got !== 8'hA5) begin n_fail++; $display("FAIL user_read: got %h want a5", got); end
        clk(EX1DR, 0);
        n_chk++; if (user_update !== 1'b0 || user_out !== 8'h00) begin n_fail++; $display("FAIL user_early: got %b/%h want 0/00", user_update, user_out); end
        clk(UPDR, 0);
        n_chk++; if (user_update !== 1'b1 || user_out !== 8'h3C) begin n_fail++; $display("FAIL user_update: got %b/%h want 1/3c", user_update, user_out); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            clk(RTI, 0);
            if (user_update !== 1'b0) pulses++;
        end
        n_chk++; if (pulses != 0) begin n_fail++; $display("FAIL user_pulse_len: got %0d extra cycles want 0", pulses); end
        n_chk++; if (user_out !== 8'h3C) begin n_fail++; $display("FAIL user_hold: got %h want 3c", user_out); end
    endtask

    task automatic test_pause;
        logic [7:0] pat, got;
        logic held;
        int hold_bad;
        user_in = 8'h5A;
        pat = 8'hC3;
        hold_bad = 0;
        clk(SELDR, 0); clk(CAPDR, 0);
        for (int i = 0; i < 4; i++) begin
            clk(SHDR, pat[i]);
            got[i] = tdo;
        end
        held = tdo;
        // tdi toggles during the pause; none of it may be shifted in.
        clk(EX1DR, 1);
        for (int i = 0; i < 3; i++) begin
            clk(PSDR, i[0]);
            if (tdo !== held || tdo_en !== 1'b0) hold_bad++;
        end
        clk(EX2DR, 1);
        n_chk++; if (hold_bad != 0 || tdo !== held) begin n_fail++; $display("FAIL pause_hold: got %0d bad cycles tdo=%b want 0 tdo=%b", hold_bad, tdo, held); end
        for (int i = 4; i < 8; i++) begin
            clk(SHDR, pat[i]);
            got[i] = tdo;
        end
        n_chk++; if (got !== 8'h5A) begin n_fail++; $display("FAIL pause_read: got %h want 5a", got); end
        clk(EX1DR, 0); clk(UPDR, 0);
        n_chk++; if (user_update !== 1'b1 || user_out !== 8'hC3) begin n_fail++; $display("FAIL pause_update: got %b/%h want 1/c3", user_update, user_out); end
        clk(RTI, 0);
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        user_in = 8'hFF;
        clk(SELDR, 0); clk(CAPDR, 0);
        for (int i = 0; i < 3; i++) clk(SHDR, 1);
        trst = 1'b1;
        clk(SHDR, 1);
        trst = 1'b0;
        n_chk++; if (user_out !== 8'h00 || ir_out !== 4'b0001) begin n_fail++; $display("FAIL midreset_regs: got %h/%b want 00/0001", user_out, ir_out); end
        n_chk++; if (tdo_en !== 1'b0 || user_update !== 1'b0) begin n_fail++; $display("FAIL midreset_outs: got en=%b upd=%b want 0 0", tdo_en, user_update); end
        // Walking on through Exit1/Update must not commit the aborted scan.
        clk(EX1DR, 0); if (user_update !== 1'b0) pulses++;
        clk(UPDR, 0);  if (user_update !== 1'b0) pulses++;
        clk(RTI, 0);   if (user_update !== 1'b0) pulses++;
        n_chk++; if (pulses != 0 || user_out !== 8'h00) begin n_fail++; $display("FAIL midreset_no_update: got %0d pulses out=%h want 0 00", pulses, user_out); end
    endtask

    task automatic test_tlr_state;
        logic [3:0] seen;
        load_ir(4'b1111, seen);
        clk(TLR, 0);
        n_chk++; if (ir_out !== 4'b0001 || tdo_en !== 1'b0) begin n_fail++; $display("FAIL tlr_reset: got ir=%b en=%b want 0001 0", ir_out, tdo_en); end
        clk(RTI, 0);
    endtask

    task automatic test_unknown_op;
        logic [3:0] seen;
        load_ir(4'b0101, seen);
        n_chk++; if (ir_out !== 4'b0101 || seen !== 4'b0001) begin n_fail++; $display("FAIL unknown_ir: got ir=%b seen=%b want 0101 0001", ir_out, seen); end
        dr_bypass_check("unknown_bypass");
    endtask

    // Back-to-back IDCODE scans with tdi=1: the second 32 bits out are the
    // pass-through ones that entered on the first scan.
    task automatic test_back_to_back;
        logic [3:0] seen;
        logic [31:0] got;
        load_ir(4'b0001, seen);
        clk(SELDR, 0); clk(CAPDR, 0);
        for (int i = 0; i < 32; i++) clk(SHDR, 1);
        for (int i = 0; i < 32; i++) begin
            clk(SHDR, 0);
            got[i] = tdo;
        end
        n_chk++; if (got !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL passthrough: got %h want ffffffff", got); end
        clk(EX1DR, 0); clk(UPDR, 0); clk(RTI, 0);
    endtask

    initial begin
        test_reset;
        test_idcode;
        test_ir_load;
        test_bypass;
        test_user;
        test_pause;
        test_reset_mid;
        test_unknown_op;
        test_tlr_state;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
